// File: rtl/hrm_io_harness.sv
// hrm_io_harness: self-checking stimulus/response harness for the hrmcpu INBOX/OUTBOX ports.
// A feeder pushes N_IN stimulus words into INBOX while a drainer concurrently pops N_OUT words
// from OUTBOX and scores them against an expected image. A watchdog aborts a stalled run.
// ROM images are packed parameters with word 0 in the least-significant DATA_W bits, so the
// block needs no file loading and the images are fixed at elaboration.

module hrm_io_harness #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_OUT   = 2,
    parameter logic [N_IN*DATA_W-1:0]  IN_INIT  = 32'h2211_1523,
    parameter logic [N_OUT*DATA_W-1:0] OUT_INIT = 16'h2A46,
    parameter int unsigned IN_GAP  = 4,
    parameter int unsigned OUT_GAP = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic              cpu_in_full,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_wr,
    input  logic              cpu_out_empty,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              cpu_out_rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              extra,
    output logic [15:0]       in_sent,
    output logic [15:0]       out_recv,
    output logic [15:0]       err_count,
    output logic [15:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_got
);

    // Counters are 16 bit, and the drainer hold phase needs at least one cycle.
    if (N_IN == 0 || N_IN > 65535 || N_OUT == 0 || N_OUT > 65535 ||
        OUT_GAP == 0 || TIMEOUT == 0) begin : g_param_check
        $error("hrm_io_harness: illegal parameter set");
    end

    localparam int unsigned L_IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned L_OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // Feeder states
    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_FEED = 2'd1;
    localparam logic [1:0] F_GAP  = 2'd2;
    localparam logic [1:0] F_DONE = 2'd3;

    // Drainer states
    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_HOLD = 2'd2;
    localparam logic [1:0] D_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_fstate;
    logic [1:0]        r_dstate;
    logic [31:0]       r_fgap;
    logic [31:0]       r_dgap;
    logic [31:0]       r_wdog;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic              r_extra;
    logic [15:0]       r_in_sent;
    logic [15:0]       r_out_recv;
    logic [15:0]       r_err_count;
    logic [15:0]       r_first_err_idx;
    logic [DATA_W-1:0] r_first_err_got;

    // ------------------------------------------------------------------
    // ROM images
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_in_rom  [N_IN];
    logic [DATA_W-1:0] w_out_rom [N_OUT];

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_rom
        assign w_in_rom[gi] = IN_INIT[gi*DATA_W +: DATA_W];
    end

    for (genvar go = 0; go < N_OUT; go++) begin : g_out_rom
        assign w_out_rom[go] = OUT_INIT[go*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              w_start;
    logic              w_abort;
    logic              w_finish;
    logic              w_wr;
    logic              w_rd;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_in_word;
    logic [DATA_W-1:0] w_exp_word;

    assign w_in_word  = w_in_rom[r_in_sent[L_IN_AW-1:0]];
    assign w_exp_word = w_out_rom[r_out_recv[L_OUT_AW-1:0]];

    // Start is only honoured from idle; this also covers the cycle in which done rises.
    assign w_start  = start && !r_busy;
    // The abort cycle suppresses both strobes so the watchdog decision is final.
    assign w_abort  = r_busy && (r_wdog >= TIMEOUT);
    assign w_finish = r_busy && !w_abort && (r_fstate == F_DONE) && (r_dstate == D_DONE);

    assign w_wr       = (r_fstate == F_FEED) && !cpu_in_full && !w_abort;
    assign w_rd       = (r_dstate == D_WAIT) && !cpu_out_empty && !w_abort;
    assign w_mismatch = w_rd && (cpu_out_data != w_exp_word);

    // ------------------------------------------------------------------
    // Run control: busy/done/result flags and the progress watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_extra   <= 1'b0;
            r_wdog    <= '0;
        end else if (w_start) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_extra   <= 1'b0;
            r_wdog    <= '0;
        end else if (w_abort) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_timeout <= 1'b1;
            r_wdog    <= '0;
        end else if (w_finish) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_extra   <= !cpu_out_empty;
            r_pass    <= (r_err_count == 16'd0) && cpu_out_empty;
            r_wdog    <= '0;
        end else if (r_busy) begin
            r_wdog    <= (w_wr || w_rd) ? 32'd0 : r_wdog + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Feeder: write one INBOX word, idle IN_GAP cycles, repeat until N_IN sent
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fstate  <= F_IDLE;
            r_fgap    <= '0;
            r_in_sent <= '0;
        end else if (w_start) begin
            r_fstate  <= F_FEED;
            r_fgap    <= '0;
            r_in_sent <= '0;
        end else if (w_abort || w_finish) begin
            r_fstate  <= F_IDLE;
        end else begin
            case (r_fstate)
                F_FEED: begin
                    if (w_wr) begin
                        r_in_sent <= r_in_sent + 16'd1;
                        r_fgap    <= '0;
                        if (IN_GAP != 0) begin
                            r_fstate <= F_GAP;
                        end else if (r_in_sent + 16'd1 == 16'(N_IN)) begin
                            r_fstate <= F_DONE;
                        end
                    end
                end
                F_GAP: begin
                    if (r_fgap == IN_GAP - 32'd1) begin
                        r_fstate <= (r_in_sent == 16'(N_IN)) ? F_DONE : F_FEED;
                    end else begin
                        r_fgap <= r_fgap + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drainer: pop and score one OUTBOX word, hold OUT_GAP cycles, repeat until N_OUT
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dstate        <= D_IDLE;
            r_dgap          <= '0;
            r_out_recv      <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_got <= '0;
        end else if (w_start) begin
            r_dstate        <= D_WAIT;
            r_dgap          <= '0;
            r_out_recv      <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_got <= '0;
        end else if (w_abort || w_finish) begin
            r_dstate        <= D_IDLE;
        end else begin
            case (r_dstate)
                D_WAIT: begin
                    if (w_rd) begin
                        r_out_recv <= r_out_recv + 16'd1;
                        r_dgap     <= '0;
                        r_dstate   <= D_HOLD;
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF) begin
                                r_err_count <= r_err_count + 16'd1;
                            end
                            // err_count never returns to zero, so zero marks the first miss
                            if (r_err_count == 16'd0) begin
                                r_first_err_idx <= r_out_recv;
                                r_first_err_got <= cpu_out_data;
                            end
                        end
                    end
                end
                D_HOLD: begin
                    if (r_dgap == OUT_GAP - 32'd1) begin
                        r_dstate <= (r_out_recv == 16'(N_OUT)) ? D_DONE : D_WAIT;
                    end else begin
                        r_dgap <= r_dgap + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_in_wr     = w_wr;
    assign cpu_in_data   = w_wr ? w_in_word : '0;
    assign cpu_out_rd    = w_rd;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign extra         = r_extra;
    assign in_sent       = r_in_sent;
    assign out_recv      = r_out_recv;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign first_err_got = r_first_err_got;

endmodule

// File: tb/tb_hrm_io_harness.sv
// Directed bench for hrm_io_harness with its default images:
// INBOX stimulus {23,15,11,22}, OUTBOX expected {46,2A}, IN_GAP=4, OUT_GAP=1, TIMEOUT=1024.

module tb_hrm_io_harness;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        start;
    logic        cpu_in_full;
    logic [7:0]  cpu_in_data;
    logic        cpu_in_wr;
    logic        cpu_out_empty;
    logic [7:0]  cpu_out_data;
    logic        cpu_out_rd;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        extra;
    logic [15:0] in_sent;
    logic [15:0] out_recv;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_got;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hrm_io_harness dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .start         (start),
        .cpu_in_full   (cpu_in_full),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_wr     (cpu_in_wr),
        .cpu_out_empty (cpu_out_empty),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_rd    (cpu_out_rd),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .extra         (extra),
        .in_sent       (in_sent),
        .out_recv      (out_recv),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_got (first_err_got)
    );

    // OUTBOX stand-in: first-word-fall-through list preloaded by the stimulus
    logic [7:0] out_mem [8];
    logic [3:0] out_wp;
    logic [3:0] out_rp;
    logic       clr;

    assign cpu_out_empty = (out_rp >= out_wp);
    assign cpu_out_data  = cpu_out_empty ? 8'h00 : out_mem[out_rp[2:0]];

    always @(posedge clk) begin
        if (clr) out_rp <= 4'd0;
        else if (cpu_out_rd && !cpu_out_empty) out_rp <= out_rp + 4'd1;
    end

    // Strobe log, sampled mid-cycle
    int         cyc = 0;
    int         wr_n;
    int         rd_n;
    int         done_cyc;
    logic       prev_done;
    logic [7:0] wr_data [16];
    int         wr_cyc [16];
    int         rd_cyc [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            wr_n      <= 0;
            rd_n      <= 0;
            done_cyc  <= -1;
            prev_done <= 1'b0;
        end else begin
            prev_done <= done;
            if (cpu_in_wr && wr_n < 16) begin
                wr_data[wr_n] <= cpu_in_data;
                wr_cyc[wr_n]  <= cyc;
                wr_n          <= wr_n + 1;
            end
            if (cpu_out_rd && rd_n < 16) begin
                rd_cyc[rd_n] <= cyc;
                rd_n         <= rd_n + 1;
            end
            if (done && !prev_done) done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("done_within_bound", 32'(done), 32'h1);
    endtask

    // Reload the OUTBOX list and clear the log; n words are presented
    task automatic setup(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [3:0] n);
        clr        = 1'b1;
        out_mem[0] = w0;
        out_mem[1] = w1;
        out_mem[2] = w2;
        out_wp     = n;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        start       = 1'b0;
        cpu_in_full = 1'b0;
        clr         = 1'b1;
        out_wp      = 4'd0;
        for (int i = 0; i < 8; i++) out_mem[i] = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_flags", 32'({busy, done, pass, timeout, extra, cpu_in_wr, cpu_out_rd}), 32'h0);
        check("rst_in_data", 32'(cpu_in_data), 32'h0);
        check("rst_counts", 32'(in_sent | out_recv | err_count | first_err_idx), 32'h0);
        check("rst_err_got", 32'(first_err_got), 32'h0);
        i_rst_n = 1'b1;
        clr     = 1'b0;
        tick();

        // Run A: clean run, 46 then 2A in OUTBOX
        setup(8'h46, 8'h2A, 8'h00, 4'd2);
        pulse_start();
        check("a_busy", 32'(busy), 32'h1);
        check("a_first_wr", 32'({cpu_in_wr, cpu_in_data}), 32'h123);
        check("a_first_rd", 32'(cpu_out_rd), 32'h1);
        wait_done(200);
        tick();
        check("a_done_held", 32'(done), 32'h1);
        check("a_pass", 32'(pass), 32'h1);
        check("a_busy_low", 32'(busy), 32'h0);
        check("a_err", 32'(err_count), 32'h0);
        check("a_extra_to", 32'({extra, timeout}), 32'h0);
        check("a_in_sent", 32'(in_sent), 32'h4);
        check("a_out_recv", 32'(out_recv), 32'h2);
        check("a_wr_n", 32'(wr_n), 32'h4);
        check("a_wr0", 32'(wr_data[0]), 32'h23);
        check("a_wr1", 32'(wr_data[1]), 32'h15);
        check("a_wr2", 32'(wr_data[2]), 32'h11);
        check("a_wr3", 32'(wr_data[3]), 32'h22);
        for (int i = 1; i < 4; i++) check("a_wr_period", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd5);
        check("a_rd_n", 32'(rd_n), 32'h2);
        check("a_rd_spacing", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);
        check("a_done_latency", 32'(done_cyc - wr_cyc[0]), 32'd21);

        // Run B: INBOX full for 10 cycles before word 2, OUTBOX 46 then 2B
        setup(8'h46, 8'h2B, 8'h00, 4'd2);
        pulse_start();
        check("b_done_cleared", 32'(done), 32'h0);
        for (int n = 0; n < 50 && in_sent != 16'd2; n++) tick();
        check("b_reach_two", 32'(in_sent), 32'h2);
        cpu_in_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 1);           // start while busy must be ignored
            tick();
        end
        start = 1'b0;
        check("b_no_wr_full", 32'(cpu_in_wr), 32'h0);
        check("b_wr_n_held", 32'(wr_n), 32'h2);
        check("b_in_sent_held", 32'(in_sent), 32'h2);
        cpu_in_full = 1'b0;
        #1;
        check("b_wr_on_release", 32'({cpu_in_wr, cpu_in_data}), 32'h111);
        wait_done(200);
        check("b_err", 32'(err_count), 32'h1);
        check("b_first_idx", 32'(first_err_idx), 32'h1);
        check("b_first_got", 32'(first_err_got), 32'h2B);
        check("b_pass", 32'(pass), 32'h0);
        check("b_extra_to", 32'({extra, timeout}), 32'h0);
        check("b_in_sent", 32'(in_sent), 32'h4);

        // Run C: a third word left in OUTBOX
        setup(8'h46, 8'h2A, 8'h77, 4'd3);
        pulse_start();
        wait_done(200);
        tick();
        check("c_extra", 32'(extra), 32'h1);
        check("c_pass", 32'(pass), 32'h0);
        check("c_err", 32'(err_count), 32'h0);
        check("c_out_recv", 32'(out_recv), 32'h2);
        check("c_rd_n", 32'(rd_n), 32'h2);

        // Run D: OUTBOX never fills, watchdog aborts
        setup(8'h00, 8'h00, 8'h00, 4'd0);
        pulse_start();
        wait_done(1500);
        tick();
        check("d_timeout", 32'(timeout), 32'h1);
        check("d_pass_busy", 32'({pass, busy}), 32'h0);
        check("d_rd_n", 32'(rd_n), 32'h0);
        check("d_in_sent", 32'(in_sent), 32'h4);
        check("d_abort_latency", 32'(done_cyc - wr_cyc[3]), 32'd1026);

        // Run E: reset mid-run, then a clean rerun
        setup(8'h46, 8'h2A, 8'h00, 4'd2);
        pulse_start();
        tick();
        tick();
        check("e_rd_before_rst", 32'(cpu_out_rd), 32'h1);
        check("e_in_sent_before", 32'(in_sent), 32'h1);
        i_rst_n = 1'b0;
        #1;
        check("e_rst_flags", 32'({busy, done, pass, timeout, extra, cpu_in_wr, cpu_out_rd}), 32'h0);
        check("e_rst_counts", 32'(in_sent | out_recv | err_count), 32'h0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        setup(8'h46, 8'h2A, 8'h00, 4'd2);
        pulse_start();
        wait_done(200);
        check("e_rerun_pass", 32'(pass), 32'h1);
        check("e_rerun_counts", 32'({in_sent, out_recv}), 32'h0004_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule
